// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DISCARD = 3'd4
  } ctrl_state_t;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CHK  = 3'd1;
  localparam logic [2:0] ERR_LEN  = 3'd2;
  localparam logic [2:0] ERR_OVF  = 3'd3;
  localparam logic [2:0] ERR_RX   = 3'd4;
  localparam logic [2:0] ERR_TMO  = 3'd5;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_fifo.sv
// Commit/rollback FIFO: writes are speculative until commit; reads only see the committed region.
// First-word fall-through read port; pointers carry one extra wrap bit.
module uart_frame_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_srst,
  input  logic                       i_wr_en,
  input  logic [7:0]                 i_wr_data,
  input  logic                       i_commit,
  input  logic                       i_rollback,
  input  logic                       i_pop,
  output logic [7:0]                 o_rd_data,
  output logic                       o_rd_valid,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_cm_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_pop;

  assign o_rd_valid = (r_rd_ptr != r_cm_ptr);
  assign w_pop      = i_pop && o_rd_valid;
  assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr[AW-1:0]] : 8'h00;
  // Committed and uncommitted bytes both occupy space until they are read.
  assign o_free     = PW'(DEPTH) - (r_wr_ptr - r_rd_ptr);

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_rollback) begin
        r_wr_ptr <= r_cm_ptr;
      end else if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_commit) begin
        r_cm_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART byte stream (SYNC, LEN, payload, CHK) into a commit/rollback FIFO.
// Optional idle timeout inside a frame: define UART_RX_FRAME_TIMEOUT_EN.
module uart_rx_frame_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         MAX_PAYLOAD  = 16,
  parameter int         FIFO_DEPTH   = 32,
  parameter int         TIMEOUT_CLKS = 104160
) (
  input  logic       IN_CLOCK,
  input  logic       IN_RESET,
  input  logic [7:0] IN_RX_DATA,
  input  logic       IN_RX_DATA_READY,
  input  logic       IN_RX_ERROR,
  output logic [7:0] OUT_DATA,
  output logic       OUT_DATA_VALID,
  input  logic       IN_DATA_READY,
  output logic       OUT_FRAME_DONE,
  output logic [4:0] OUT_FRAME_LEN,
  output logic       OUT_FRAME_ERR,
  output logic [2:0] OUT_ERR_CODE,
  output logic       OUT_BUSY
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  // Byte and frame counters are 5 bits wide, so LEN+1 must stay below 32.
  if (TIMEOUT_CLKS < 2 || MAX_PAYLOAD > 30 ||
      FIFO_DEPTH != (1 << $clog2(FIFO_DEPTH))) begin : g_param_check
    $error("uart_rx_frame_ctrl: unsupported parameter set");
  end

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_next;
  logic [4:0]  r_len;
  logic [4:0]  w_len_next;
  logic [7:0]  r_csum;
  logic [7:0]  w_csum_next;
  logic        r_frame_done;
  logic        r_frame_err;
  logic [2:0]  r_err_code;
  logic [4:0]  r_frame_len;

  logic          w_byte;
  logic          w_tmo_hit;
  logic          w_wr_en;
  logic          w_commit;
  logic          w_rollback;
  logic          w_done;
  logic          w_err;
  logic [2:0]    w_err_code;
  logic [PW-1:0] w_free;

  assign w_byte = IN_RX_DATA_READY && !IN_RX_ERROR;

`ifdef UART_RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET || r_state == ST_IDLE || IN_RX_DATA_READY || IN_RX_ERROR) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo_cnt == TW'(TIMEOUT_CLKS - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  uart_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (IN_CLOCK),
    .i_srst     (IN_RESET),
    .i_wr_en    (w_wr_en),
    .i_wr_data  (IN_RX_DATA),
    .i_commit   (w_commit),
    .i_rollback (w_rollback),
    .i_pop      (IN_DATA_READY),
    .o_rd_data  (OUT_DATA),
    .o_rd_valid (OUT_DATA_VALID),
    .o_free     (w_free)
  );

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_csum       <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_frame_len  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_len        <= w_len_next;
      r_csum       <= w_csum_next;
      r_frame_done <= w_done;
      r_frame_err  <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
      end
      if (w_done) begin
        r_frame_len <= r_len;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_len_next   = r_len;
    w_csum_next  = r_csum;
    w_wr_en      = 1'b0;
    w_commit     = 1'b0;
    w_rollback   = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_err_code   = ERR_NONE;

    // Receiver error outranks a byte in the same cycle; a byte outranks the timeout.
    if (r_state != ST_IDLE && IN_RX_ERROR) begin
      w_state_next = ST_IDLE;
      if (r_state != ST_DISCARD) begin
        w_rollback = 1'b1;
        w_err      = 1'b1;
        w_err_code = ERR_RX;
      end
    end else if (w_byte) begin
      case (r_state)
        ST_IDLE: begin
          if (IN_RX_DATA == SYNC_BYTE) begin
            w_state_next = ST_LEN;
          end
        end
        ST_LEN: begin
          if (IN_RX_DATA > 8'(MAX_PAYLOAD)) begin
            w_err        = 1'b1;
            w_err_code   = ERR_LEN;
            w_state_next = ST_IDLE;
          end else if (32'(w_free) < 32'(IN_RX_DATA)) begin
            w_err        = 1'b1;
            w_err_code   = ERR_OVF;
            w_cnt_next   = IN_RX_DATA[4:0] + 5'd1;
            w_state_next = ST_DISCARD;
          end else begin
            w_len_next   = IN_RX_DATA[4:0];
            w_cnt_next   = IN_RX_DATA[4:0];
            w_csum_next  = IN_RX_DATA;
            w_state_next = (IN_RX_DATA == 8'd0) ? ST_CHK : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          w_wr_en     = 1'b1;
          w_csum_next = r_csum ^ IN_RX_DATA;
          w_cnt_next  = r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            w_state_next = ST_CHK;
          end
        end
        ST_CHK: begin
          w_state_next = ST_IDLE;
          if (IN_RX_DATA == r_csum) begin
            w_commit = 1'b1;
            w_done   = 1'b1;
          end else begin
            w_rollback = 1'b1;
            w_err      = 1'b1;
            w_err_code = ERR_CHK;
          end
        end
        ST_DISCARD: begin
          w_cnt_next = r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            w_state_next = ST_IDLE;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end else if (w_tmo_hit) begin
      w_state_next = ST_IDLE;
      if (r_state != ST_DISCARD) begin
        w_rollback = 1'b1;
        w_err      = 1'b1;
        w_err_code = ERR_TMO;
      end
    end
  end

  assign OUT_FRAME_DONE = r_frame_done;
  assign OUT_FRAME_LEN  = r_frame_len;
  assign OUT_FRAME_ERR  = r_frame_err;
  assign OUT_ERR_CODE   = r_err_code;
  assign OUT_BUSY       = (r_state != ST_IDLE);

endmodule
